// File: rtl/serial_adder_pkg.sv
// Shared state encodings and sizing helper for the bit-serial adder.
package serial_adder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Bit counter width: ceil(log2(w)), never less than one bit.
   function automatic int cnt_width(input int w);
      return (w <= 2) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/serial_adder_fa_cell.sv
// 1-bit full adder: two half-adder stages with the stage carries ORed.
module fa_cell (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   logic p;
   logic g1;
   logic g2;

   assign p    = a ^ b;
   assign g1   = a & b;
   assign s    = p ^ cin;
   assign g2   = p & cin;
   assign cout = g1 | g2;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: LSB-first, one bit per clock, single carry flop.
//
//  state   | meaning
//  --------+---------------------------------------------------------
//  ST_IDLE | waiting for start; sum/cout hold the last result
//  ST_RUN  | adding one bit per cycle; start is ignored
//  ST_DONE | one-cycle done pulse; start here begins the next add
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int            CW       = cnt_width(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   state_t           state_q;
   state_t           state_d;
   logic             load;
   logic [CW-1:0]    cnt_q;
   logic             carry_q;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] res_sh;
   logic [WIDTH-1:0] res_next;
   logic [WIDTH-1:0] sum_q;
   logic             cout_q;
   logic             s_bit;
   logic             c_bit;

   fa_cell u_fa (
      .a    (a_sh[0]),
      .b    (b_sh[0]),
      .cin  (carry_q),
      .s    (s_bit),
      .cout (c_bit)
   );

   // The new sum bit enters at the MSB so the word is aligned after WIDTH shifts.
   assign res_next = {s_bit, res_sh[WIDTH-1:1]};

   // Next-state decode; the unused encoding falls back to IDLE.
   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               load    = 1'b1;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (cnt_q == CNT_LAST) state_d = ST_DONE;
         end
         ST_DONE: begin
            if (start) begin
               load    = 1'b1;
               state_d = ST_RUN;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Serial datapath: operand shifters, carry, bit counter and result capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_sh    <= '0;
         b_sh    <= '0;
         res_sh  <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
      end else if (load) begin
         a_sh    <= a;
         b_sh    <= b;
         carry_q <= 1'b0;
         cnt_q   <= '0;
      end else if (state_q == ST_RUN) begin
         a_sh    <= a_sh >> 1;
         b_sh    <= b_sh >> 1;
         res_sh  <= res_next;
         carry_q <= c_bit;
         cnt_q   <= cnt_q + CW'(1);
         if (cnt_q == CNT_LAST) begin
            sum_q  <= res_next;
            cout_q <= c_bit;
         end
      end
   end

   assign busy = (state_q == ST_RUN);
   assign done = (state_q == ST_DONE);
   assign sum  = sum_q;
   assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: an 8-bit instance for directed cases and
// a 4-bit instance swept over every operand pair.
module tb_serial_adder;

   logic       clk = 1'b0;
   logic       rst;
   logic       start8;
   logic [7:0] a8, b8, sum8;
   logic       busy8, done8, cout8;
   logic       start4;
   logic [3:0] a4, b4, sum4;
   logic       busy4, done4, cout4;

   int checks = 0;
   int errors = 0;

   logic [8:0] q8[$];
   logic [4:0] q4[$];
   logic [8:0] e8;
   logic [4:0] e4;

   always #5 clk = ~clk;

   serial_adder #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
      .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
   );

   serial_adder #(.WIDTH(4)) dut4 (
      .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
      .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Monitor for the 8-bit instance: every done pulse consumes one expected result.
   always @(negedge clk) begin
      if (!rst && done8) begin
         if (q8.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done8 actual=%0h required=none", {cout8, sum8});
         end else begin
            e8 = q8.pop_front();
            chk("result8", {23'd0, cout8, sum8}, {23'd0, e8});
         end
      end
   end

   // Monitor for the 4-bit instance.
   always @(negedge clk) begin
      if (!rst && done4) begin
         if (q4.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done4 actual=%0h required=none", {cout4, sum4});
         end else begin
            e4 = q4.pop_front();
            chk("result4", {27'd0, cout4, sum4}, {27'd0, e4});
         end
      end
   end

   task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic [8:0] exp,
                          output int lat, output int busy_n);
      @(negedge clk);
      a8 = a; b8 = b; start8 = 1'b1;
      q8.push_back(exp);
      lat = 0; busy_n = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         start8 = 1'b0;
         lat++;
         if (busy8) busy_n++;
         if (done8) break;
      end
      chk("done8_seen", {31'd0, done8}, 32'd1);
   endtask

   int lat, busy_n, n_done;

   initial begin
      rst = 1'b1; start8 = 1'b0; a8 = '0; b8 = '0;
      start4 = 1'b0; a4 = '0; b4 = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("reset_busy", {31'd0, busy8}, 32'd0);
      chk("reset_done", {31'd0, done8}, 32'd0);
      chk("reset_sum",  {24'd0, sum8}, 32'd0);
      chk("reset_cout", {31'd0, cout8}, 32'd0);

      // 0x35 + 0x1A = 0x4F
      run_op8(8'h35, 8'h1A, 9'h04F, lat, busy_n);
      chk("latency_35_1a", lat, 9);
      chk("busy_cycles",   busy_n, 8);

      // carry ripple cases
      run_op8(8'hFF, 8'h01, 9'h100, lat, busy_n);
      chk("latency_ff_01", lat, 9);
      run_op8(8'hFF, 8'hFF, 9'h1FE, lat, busy_n);

      // start re-pulsed with zero operands during RUN must be ignored
      @(negedge clk);
      a8 = 8'h35; b8 = 8'h1A; start8 = 1'b1;
      q8.push_back(9'h04F);
      lat = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         lat++;
         start8 = (lat == 3);
         if (lat == 3) begin a8 = 8'h00; b8 = 8'h00; end
         if (done8) break;
      end
      start8 = 1'b0;
      chk("ignore_done_seen", {31'd0, done8}, 32'd1);
      chk("ignore_latency", lat, 9);
      n_done = 0;
      repeat (12) begin
         @(negedge clk);
         if (done8) n_done++;
      end
      chk("ignore_single_done", n_done, 0);
      chk("ignore_idle_busy", {31'd0, busy8}, 32'd0);

      // reset three cycles into RUN aborts with no done pulse
      @(negedge clk);
      a8 = 8'h35; b8 = 8'h1A; start8 = 1'b1;
      @(negedge clk); start8 = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("abort_busy_before", {31'd0, busy8}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy", {31'd0, busy8}, 32'd0);
      chk("abort_done", {31'd0, done8}, 32'd0);
      chk("abort_sum",  {24'd0, sum8}, 32'd0);
      chk("abort_cout", {31'd0, cout8}, 32'd0);
      n_done = 0;
      repeat (12) begin
         @(negedge clk);
         if (done8) n_done++;
      end
      chk("abort_no_done", n_done, 0);
      run_op8(8'h0F, 8'h01, 9'h010, lat, busy_n);
      chk("after_abort_latency", lat, 9);

      // back-to-back: start held in the DONE cycle with 0x80 + 0x80
      a8 = 8'h80; b8 = 8'h80; start8 = 1'b1;
      q8.push_back(9'h100);
      lat = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         start8 = 1'b0;
         lat++;
         if (lat == 1) chk("b2b_busy", {31'd0, busy8}, 32'd1);
         if (done8) break;
         chk("b2b_sum_held", {23'd0, cout8, sum8}, 32'h010);
      end
      chk("b2b_done_seen", {31'd0, done8}, 32'd1);
      chk("b2b_latency", lat, 9);
      repeat (2) @(negedge clk);

      // WIDTH=4 exhaustive sweep
      for (int ai = 0; ai < 16; ai++) begin
         for (int bi = 0; bi < 16; bi++) begin
            @(negedge clk);
            a4 = 4'(ai); b4 = 4'(bi); start4 = 1'b1;
            q4.push_back(5'(ai + bi));
            for (int i = 0; i < 20; i++) begin
               @(negedge clk);
               start4 = 1'b0;
               if (done4) break;
            end
            chk("done4_seen", {31'd0, done4}, 32'd1);
         end
      end

      repeat (3) @(negedge clk);
      chk("q8_drained", q8.size(), 0);
      chk("q4_drained", q4.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
